// File: rtl/tdm_demux2.sv
// Two-slot TDM receiver: recovers d0/d1 from a sync-marked word stream into frame-coherent registers.
// Optional saturating error counter port enabled by defining TDM_DEMUX_ERRCNT_EN.
module tdm_demux2 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_vld,
   input  logic             sync,
   output logic [WIDTH-1:0] d0,
   output logic [WIDTH-1:0] d1,
   output logic             sel,
   output logic             locked,
   output logic             frame_vld,
   output logic             err
`ifdef TDM_DEMUX_ERRCNT_EN
   ,
   output logic [7:0]       err_cnt
`endif
);

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      SLOT1 = 2'd1,
      SLOT0 = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] stage_q, stage_d;
   logic [WIDTH-1:0] d0_q, d0_d;
   logic [WIDTH-1:0] d1_q, d1_d;
   logic             frame_vld_q, frame_vld_d;
   logic             err_q, err_d;

   always_comb begin
      state_d     = state_q;
      stage_d     = stage_q;
      d0_d        = d0_q;
      d1_d        = d1_q;
      frame_vld_d = 1'b0;
      err_d       = 1'b0;
      if (din_vld) begin
         unique case (state_q)
            HUNT: begin
               if (sync) begin
                  stage_d = din;
                  state_d = SLOT1;
               end
            end
            SLOT1: begin
               if (!sync) begin
                  // Both channels commit together so a partial frame never reaches the outputs
                  d0_d        = stage_q;
                  d1_d        = din;
                  frame_vld_d = 1'b1;
                  state_d     = SLOT0;
               end else begin
                  err_d   = 1'b1;
                  stage_d = din;
               end
            end
            SLOT0: begin
               if (sync) begin
                  stage_d = din;
                  state_d = SLOT1;
               end else begin
                  err_d   = 1'b1;
                  state_d = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= HUNT;
         stage_q     <= '0;
         d0_q        <= '0;
         d1_q        <= '0;
         frame_vld_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         stage_q     <= stage_d;
         d0_q        <= d0_d;
         d1_q        <= d1_d;
         frame_vld_q <= frame_vld_d;
         err_q       <= err_d;
      end
   end

   assign d0        = d0_q;
   assign d1        = d1_q;
   assign frame_vld = frame_vld_q;
   assign err       = err_q;
   assign sel       = (state_q == SLOT1);
   assign locked    = (state_q != HUNT);

`ifdef TDM_DEMUX_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Counts alongside err_d so the count moves in the same cycle the err pulse is visible
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_cnt_q <= '0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule
